bist_pattern_ctrl: RTL and testbench
====================================

BIST_PATTERN_CTRL -- requirements
Module: bist_pattern_ctrl

Interface
REQ-001 Parameter N_PAT, default 16'd255: number of test patterns applied per session (legal range 1..65535).
REQ-002 Parameter INIT_CYC, default 4: number of CUT flush cycles before pattern application (legal range 1..15).
REQ-003 Parameter LFSR_SEED, default 16'hACE1: nonzero LFSR start value.
REQ-004 Parameter GOLDEN_SIG, default 16'h0000: expected MISR signature for a fault-free CUT.
REQ-005 CK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  synchronous reset, active-high.
REQ-007 start  input  1  one-cycle request to begin a test session.
REQ-008 tpg_out  output  3  stimulus driven to CUT inputs {G2,G1,G0}.
REQ-009 resp_in  input  6  CUT responses {G133,G132,G118,G117,G67,G66}.
REQ-010 busy  output  1  high in INIT, RUN or DRAIN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  valid when done=1: signature equals GOLDEN_SIG.
REQ-013 signature  output  16  current MISR contents.
REQ-014 abort  input  1  present only with BIST_ABORT_EN (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, INIT, RUN, DRAIN, DONE.
REQ-016 IDLE: tpg_out=3'b000, misr held; start=1 -> INIT, with lfsr<=LFSR_SEED, misr<=0, counter<=0.
REQ-017 INIT: tpg_out=3'b001 (G0 asserted, flushes CUT state) for exactly INIT_CYC cycles, no compaction, then RUN.
REQ-018 RUN: tpg_out=lfsr[2:0]; lfsr SHALL advance every RUN cycle as a left-shifting Fibonacci LFSR, feedback = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10] into bit 0.
REQ-019 RUN lasts exactly N_PAT cycles (pattern counter 0..N_PAT-1), then DRAIN.
REQ-020 MISR update SHALL be misr <= {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ {10'b0, resp_in}.
REQ-021 MISR SHALL update on RUN cycles with counter>=1 and on the single DRAIN cycle, giving exactly N_PAT compactions (one-cycle CUT latency).
REQ-022 DRAIN: tpg_out=3'b000, one cycle, then DONE.
REQ-023 DONE: signature frozen; done=1; pass=(misr==GOLDEN_SIG); start=1 -> INIT with full re-seed as in REQ-016.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 N_PAT=1: RUN one cycle with no compaction, DRAIN compacts once.
REQ-026 pass SHALL be 0 whenever done=0.
REQ-027 Counters SHALL not wrap: 16-bit pattern counter, 4-bit init counter, compared against parameters, never overflow for legal values.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE, lfsr=LFSR_SEED, misr=0, counters=0, regardless of current state, including mid-RUN.
REQ-029 Post-reset outputs: tpg_out=0, busy=0, done=0, pass=0, signature=0.
REQ-030 RST SHALL take priority over start and abort in the same cycle.

Configuration
REQ-031 Macro BIST_ABORT_EN defined: abort port exists; abort=1 in INIT/RUN/DRAIN -> IDLE next edge, misr preserved, done=0; ignored in IDLE/DONE; start and abort together while idle: abort wins.
REQ-032 BIST_ABORT_EN undefined: no abort port; a session always runs to DONE.

Verification
REQ-033 Reset then start pulse, resp_in=0, N_PAT=255 -> busy high for 4+255+1=260 cycles, done rises next, signature=16'h0000, pass=1.
REQ-034 First pattern after INIT with default seed -> tpg_out=3'b001 (16'hACE1[2:0]) on RUN cycle 0; next pattern derived per REQ-018 matches reference model.
REQ-035 N_PAT=1, resp_in=6'h3F constant -> exactly one compaction, signature=16'h003F, pass=0.
REQ-036 RST pulse at RUN cycle 100 -> next cycle busy=0, signature=0; subsequent start reproduces bit-identical tpg_out sequence.
REQ-037 start asserted during RUN -> no effect on counter or sequence; start in DONE -> new session, identical signature for identical resp_in.
REQ-038 BIST_ABORT_EN: abort at RUN cycle 10 -> IDLE next edge, done=0, pass=0; without macro, build has no abort port.

Source files
------------

// File: rtl/bist_pattern_ctrl.sv
// bist_pattern_ctrl: LFSR pattern generator + MISR compactor BIST session controller; optional abort input under BIST_ABORT_EN.
module bist_pattern_ctrl #(
  parameter logic [15:0] N_PAT      = 16'd255,
  parameter logic [3:0]  INIT_CYC   = 4'd4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        start,
`ifdef BIST_ABORT_EN
  input  logic        abort,
`endif
  input  logic [5:0]  resp_in,
  output logic [2:0]  tpg_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
  state_t st, nxt;
  logic [15:0] lfsr, misr, pcnt;
  logic [3:0] icnt;
  logic ab, launch, compact;
`ifdef BIST_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  assign launch = start && (st == DONE || (st == IDLE && !ab));
  // responses lag their pattern by one cycle, so RUN cycle 0 has nothing to compact
  assign compact = !ab && ((st == RUN && pcnt != 16'd0) || st == DRAIN);
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE, DONE: nxt = launch ? INIT : st;
      INIT:       nxt = ab ? IDLE : (icnt == INIT_CYC - 4'd1) ? RUN : INIT;
      RUN:        nxt = ab ? IDLE : (pcnt == N_PAT - 16'd1) ? DRAIN : RUN;
      DRAIN:      nxt = ab ? IDLE : DONE;
      default:    nxt = IDLE;
    endcase
  end
  assign tpg_out   = st == INIT ? 3'b001 : st == RUN ? lfsr[2:0] : 3'b000;
  assign busy      = st == INIT || st == RUN || st == DRAIN;
  assign done      = st == DONE;
  assign pass      = done && misr == GOLDEN_SIG;
  assign signature = misr;
  always_ff @(posedge CK) begin
    if (RST) begin
      st   <= IDLE;
      lfsr <= LFSR_SEED;
      misr <= '0;
      pcnt <= '0;
      icnt <= '0;
    end else begin
      st <= nxt;
      if (launch) begin
        lfsr <= LFSR_SEED;
        misr <= '0;
        pcnt <= '0;
        icnt <= '0;
      end else begin
        if (st == INIT && !ab) icnt <= icnt + 4'd1;
        if (st == RUN && !ab) begin
          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          pcnt <= pcnt + 16'd1;
        end
        if (compact) misr <= {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ {10'b0, resp_in};
      end
    end
  end
endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// tb_bist_pattern_ctrl: session-level reference model of the BIST controller checked every cycle, plus literal pins.
module tb_bist_pattern_ctrl;
  localparam int INIT = 4;
  localparam int N = 255;
  logic CK = 0, RST = 1, start = 0, abort = 0, start1 = 0;
  logic [5:0] resp_in = '0;
  logic [2:0] tpg_out, tpg1;
  logic busy, done, pass, busy1, done1, pass1;
  logic [15:0] signature, sig1;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  always #5 CK = ~CK;

  bist_pattern_ctrl dut (
    .CK(CK), .RST(RST), .start(start),
`ifdef BIST_ABORT_EN
    .abort(abort),
`endif
    .resp_in(resp_in), .tpg_out(tpg_out), .busy(busy), .done(done), .pass(pass), .signature(signature));

  bist_pattern_ctrl #(.N_PAT(16'd1)) dut1 (
    .CK(CK), .RST(RST), .start(start1),
`ifdef BIST_ABORT_EN
    .abort(1'b0),
`endif
    .resp_in(6'h3F), .tpg_out(tpg1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mstep(input logic [15:0] m, input logic [5:0] r);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, r};
  endfunction

  // pattern sequence as an array: pats[j] is the LFSR value on RUN cycle j
  logic [15:0] pats [0:N-1];
  logic [5:0] tbl [0:299];
  initial begin
    logic [15:0] p;
    p = 16'hACE1;
    for (int j = 0; j < N; j++) begin
      pats[j] = p;
      p = {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
    end
    for (int j = 0; j < 300; j++) tbl[j] = 6'($urandom);
  end

  // session model: mode 0 idle, 1 busy (k = cycles since launch), 2 done
  int m_mode = 0, m_k = 0;
  logic [15:0] m_sig = '0;
  always @(posedge CK) begin
    if (RST) begin
      m_mode <= 0; m_k <= 0; m_sig <= '0;
    end else if (m_mode == 1 && abort) m_mode <= 0;
    else if (m_mode != 1 && start && !(m_mode == 0 && abort)) begin
      m_mode <= 1; m_k <= 0; m_sig <= '0;
    end else if (m_mode == 1) begin
      m_k <= m_k + 1;
      if (m_k > INIT && m_k <= INIT + N) m_sig <= mstep(m_sig, resp_in);
      if (m_k == INIT + N) m_mode <= 2;
    end
  end

  always @(negedge CK) if (chk_en) begin
    logic [2:0] et;
    et = m_mode != 1 ? 3'd0 : m_k < INIT ? 3'd1 : m_k < INIT + N ? pats[m_k - INIT][2:0] : 3'd0;
    chk("tpg_out", 32'(tpg_out), 32'(et));
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("pass", 32'(pass), 32'(m_mode == 2 && m_sig == 16'h0000));
    chk("signature", 32'(signature), 32'(m_sig));
  end

  logic [2:0] qcur[$], qa[$];

  task automatic go();
    start = 1;
    @(negedge CK);
    start = 0;
    qcur.delete();
  endtask

  task automatic run(input bit use_tbl, input bit noise, output int nb);
    nb = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (busy) nb++;
      if (m_mode == 1 && m_k == INIT) chk("run0_tpg", 32'(tpg_out), 32'h1);
      if (m_mode == 1 && m_k == INIT + 1) chk("run1_tpg", 32'(tpg_out), 32'h3);
      if (m_mode == 1 && m_k >= INIT && m_k < INIT + N) qcur.push_back(tpg_out);
      resp_in = use_tbl ? tbl[m_k] : 6'd0;
      start = noise && $urandom_range(0, 7) == 0;
      @(negedge CK);
    end
    start = 0;
    chk("session_done", 32'(done), 32'h1);
  endtask

  task automatic wait_k(input int target);
    for (int i = 0; i < 400 && !(m_mode == 1 && m_k == target); i++) @(negedge CK);
    chk("reach_k", 32'(m_k), 32'(target));
  endtask

  initial begin
    int nb, bad;
    logic [15:0] sig_b;
    chk("model_pat0", 32'(pats[0]), 32'hACE1);
    chk("model_pat1", 32'(pats[1]), 32'h59C3);
    chk("model_mstep", 32'(mstep(16'h0000, 6'h3F)), 32'h003F);
    repeat (2) @(negedge CK);
    RST = 0;
    chk_en = 1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sig", 32'(signature), 32'h0);
    chk("rst_tpg", 32'(tpg_out), 32'h0);
    // single-pattern instance: one compaction of 6'h3F
    start1 = 1;
    @(negedge CK);
    start1 = 0;
    nb = 0;
    for (int i = 0; i < 20 && !done1; i++) begin
      if (busy1) nb++;
      @(negedge CK);
    end
    chk("npat1_busy_len", 32'(nb), 32'd6);
    chk("npat1_sig", 32'(sig1), 32'h003F);
    chk("npat1_pass", 32'(pass1), 32'h0);
    chk("npat1_done", 32'(done1), 32'h1);
    // all-zero responses: fault-free golden run
    go();
    run(0, 0, nb);
    qa = qcur;
    chk("busy_len", 32'(nb), 32'd260);
    chk("zero_sig", 32'(signature), 32'h0);
    chk("zero_pass", 32'(pass), 32'h1);
    // restart from DONE with random responses and stray start pulses
    go();
    run(1, 1, nb);
    sig_b = signature;
    chk("noise_busy_len", 32'(nb), 32'd260);
    go();
    run(1, 0, nb);
    chk("repeat_sig", 32'(signature), 32'(sig_b));
    // reset mid-RUN, then the sequence must restart identically
    go();
    wait_k(INIT + 100);
    RST = 1;
    @(negedge CK);
    RST = 0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_sig", 32'(signature), 32'h0);
    go();
    run(0, 0, nb);
    bad = 0;
    for (int j = 0; j < qa.size() && j < qcur.size(); j++) if (qa[j] !== qcur[j]) bad++;
    chk("repro_len", 32'(qcur.size()), 32'(qa.size()));
    chk("repro_seq", 32'(bad), 32'd0);
`ifdef BIST_ABORT_EN
    go();
    resp_in = 6'h15;
    wait_k(INIT + 10);
    abort = 1;
    @(negedge CK);
    abort = 0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_pass", 32'(pass), 32'h0);
    start = 1;
    abort = 1;
    @(negedge CK);
    start = 0;
    abort = 0;
    chk("abort_wins", 32'(busy), 32'h0);
`endif
    @(negedge CK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
